cmos_8_n_pack: RTL and testbench

CMOS_8_N_PACK -- requirements
Module: cmos_8_n_pack

---
 rtl/cmos_8_n_pack.sv | 154 +++++++++++++++
 tb/tb_cmos_8_n_pack.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_8_n_pack.sv
// cmos_8_n_pack
//   Packs an 8-bit CMOS sensor byte stream into BPP-byte pixels.
//   Bytes are qualified by de_i (href). Every BPP captured bytes form
//   one pixel, which is presented on pdata_o with a one-cycle pvld_o strobe.
//   A line is counted when it ends after emitting at least one pixel.
//   A line that ends part-way through a pixel raises err_partial.
//
// Parameters
//   BPP    bytes per output pixel (2..4)
//   CNT_W  width of the pixel and line counters
//
// Ports
//   pclk        sole clock, rising edge
//   rst         asynchronous active-high reset
//   pdata_i     sensor byte
//   de_i        line valid / byte qualifier
//   vs_i        frame sync, active high
//   msb_first   1: first byte of a pixel lands in the MSB, 0: in the LSB
//   pdata_o     packed pixel, held between strobes
//   pvld_o      one-cycle strobe qualifying pdata_o
//   hblank      registered ~de_i
//   vs_o        vs_i delayed one cycle
//   pix_cnt_o   pixels emitted on the current line (saturating)
//   line_cnt_o  lines completed in the current frame (saturating)
//   err_partial one-cycle pulse: line ended mid-pixel
//
// Build option
//   CMOS_PACK_BYTE_SWAP_EN  when defined, msb_first selects byte order;
//                           otherwise order is fixed MSB-first.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// WAIT_LOW | after reset; discard bytes until de_i has been seen low
// IDLE     | between lines; a de_i high starts a line and its byte is kept
// ACTIVE   | inside a line; capture bytes while de_i is high

module cmos_8_n_pack #(
   parameter int BPP   = 2,
   parameter int CNT_W = 12
) (
   input  logic               pclk,
   input  logic               rst,
   input  logic [7:0]         pdata_i,
   input  logic               de_i,
   input  logic               vs_i,
   input  logic               msb_first,
   output logic [8*BPP-1:0]   pdata_o,
   output logic               pvld_o,
   output logic               hblank,
   output logic               vs_o,
   output logic [CNT_W-1:0]   pix_cnt_o,
   output logic [CNT_W-1:0]   line_cnt_o,
   output logic               err_partial
);

   localparam int BW = (BPP > 2) ? 2 : 1;
   localparam logic [BW-1:0] BCNT_LAST = BW'(BPP - 1);

   typedef enum logic [1:0] {
      WAIT_LOW = 2'd0,
      IDLE     = 2'd1,
      ACTIVE   = 2'd2
   } state_t;

   state_t            state;
   logic [BW-1:0]     bcnt;
   logic [8*BPP-1:0]  acc;
   logic [8*BPP-1:0]  acc_next;
   logic [BW-1:0]     byte_pos;
   logic              order_msb;
   logic              capture;
   logic              last_byte;
   logic              line_start;
   logic              line_end;
   logic              vs_rise;

`ifdef CMOS_PACK_BYTE_SWAP_EN
   assign order_msb = msb_first;
`else
   // msb_first has no effect in this build; order is always MSB-first.
   assign order_msb = msb_first | 1'b1;
`endif

   assign capture    = de_i & ((state == IDLE) | (state == ACTIVE));
   assign last_byte  = capture & (bcnt == BCNT_LAST);
   assign line_start = (state == IDLE) & de_i;
   assign line_end   = (state == ACTIVE) & ~de_i;
   // vs_o is vs_i one cycle late, so it doubles as the edge-detect history.
   assign vs_rise    = vs_i & ~vs_o;
   assign byte_pos   = order_msb ? (BCNT_LAST - bcnt) : bcnt;

   // Each pixel starts from zero so stale bytes never leak into a new pixel
   // when msb_first changes between bytes of the same pixel.
   always_comb begin
      acc_next = (bcnt == '0) ? '0 : acc;
      for (int i = 0; i < BPP; i++) begin
         if (byte_pos == BW'(i)) begin
            acc_next[8*i +: 8] = pdata_i;
         end
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state       <= WAIT_LOW;
         bcnt        <= '0;
         acc         <= '0;
         pdata_o     <= '0;
         pvld_o      <= 1'b0;
         hblank      <= 1'b1;
         vs_o        <= 1'b0;
         pix_cnt_o   <= '0;
         line_cnt_o  <= '0;
         err_partial <= 1'b0;
      end else begin
         hblank      <= ~de_i;
         vs_o        <= vs_i;
         pvld_o      <= last_byte;
         err_partial <= line_end & (bcnt != '0);

         case (state)
            WAIT_LOW: if (!de_i) state <= IDLE;
            IDLE:     if (de_i)  state <= ACTIVE;
            ACTIVE:   if (!de_i) state <= IDLE;
            default:  state <= WAIT_LOW;
         endcase

         if (capture) begin
            acc  <= acc_next;
            bcnt <= last_byte ? '0 : bcnt + 1'b1;
            if (last_byte) begin
               pdata_o <= acc_next;
            end
         end else if (line_end) begin
            bcnt <= '0;
         end

         if (vs_rise || line_start) begin
            pix_cnt_o <= '0;
         end else if (last_byte && (pix_cnt_o != '1)) begin
            pix_cnt_o <= pix_cnt_o + 1'b1;
         end

         // Frame sync wins over a line completing in the same cycle.
         if (vs_rise) begin
            line_cnt_o <= '0;
         end else if (line_end && ((pix_cnt_o != '0) || last_byte) &&
                      (line_cnt_o != '1)) begin
            line_cnt_o <= line_cnt_o + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cmos_8_n_pack.sv
// Bench for cmos_8_n_pack: three instances (BPP=2/3/4, the BPP=4 one with
// 3-bit counters to reach saturation) share one stimulus stream. Each line's
// bytes are kept in a queue and the expected pixels, counts and error pulses
// are computed from that byte list.
module tb_cmos_8_n_pack;

   logic        pclk = 1'b0;
   logic        rst;
   logic [7:0]  pdata_i;
   logic        de_i;
   logic        vs_i;
   logic        msb_first;

   logic [15:0] po2;
   logic [23:0] po3;
   logic [31:0] po4;
   logic        pv2, pv3, pv4, hb2, hb3, hb4, vo2, vo3, vo4, er2, er3, er4;
   logic [11:0] pc2, lc2, pc3, lc3;
   logic [2:0]  pc4, lc4;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0] cur_bytes[$];
   bit         cur_msb[$];
   longint     mq2[$], mq3[$], mq4[$];
   int         ec[3];
   int         fc[3];
   int         line_exp[3];
   int         start_cyc;

   cmos_8_n_pack #(.BPP(2), .CNT_W(12)) d2 (
      .pclk(pclk), .rst(rst), .pdata_i(pdata_i), .de_i(de_i), .vs_i(vs_i),
      .msb_first(msb_first), .pdata_o(po2), .pvld_o(pv2), .hblank(hb2),
      .vs_o(vo2), .pix_cnt_o(pc2), .line_cnt_o(lc2), .err_partial(er2));

   cmos_8_n_pack #(.BPP(3), .CNT_W(12)) d3 (
      .pclk(pclk), .rst(rst), .pdata_i(pdata_i), .de_i(de_i), .vs_i(vs_i),
      .msb_first(msb_first), .pdata_o(po3), .pvld_o(pv3), .hblank(hb3),
      .vs_o(vo3), .pix_cnt_o(pc3), .line_cnt_o(lc3), .err_partial(er3));

   cmos_8_n_pack #(.BPP(4), .CNT_W(3)) d4 (
      .pclk(pclk), .rst(rst), .pdata_i(pdata_i), .de_i(de_i), .vs_i(vs_i),
      .msb_first(msb_first), .pdata_o(po4), .pvld_o(pv4), .hblank(hb4),
      .vs_o(vo4), .pix_cnt_o(pc4), .line_cnt_o(lc4), .err_partial(er4));

   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   always @(posedge pclk) begin
      #1;
      if (pv2) begin if (mq2.size() == 0) fc[0] = cyc; mq2.push_back(longint'(po2)); end
      if (pv3) begin if (mq3.size() == 0) fc[1] = cyc; mq3.push_back(longint'(po3)); end
      if (pv4) begin if (mq4.size() == 0) fc[2] = cyc; mq4.push_back(longint'(po4)); end
      if (er2) ec[0]++;
      if (er3) ec[1]++;
      if (er4) ec[2]++;
   end

   function automatic int mon_size(input int d);
      case (d)
         0: return mq2.size();
         1: return mq3.size();
         default: return mq4.size();
      endcase
   endfunction

   function automatic longint mon_val(input int d, input int j);
      case (d)
         0: return mq2[j];
         1: return mq3[j];
         default: return mq4[j];
      endcase
   endfunction

   function automatic int pix_of(input int d);
      case (d)
         0: return int'(pc2);
         1: return int'(pc3);
         default: return int'(pc4);
      endcase
   endfunction

   function automatic int line_of(input int d);
      case (d)
         0: return int'(lc2);
         1: return int'(lc3);
         default: return int'(lc4);
      endcase
   endfunction

   // {pvld, err_partial, vs_o, hblank}
   function automatic logic [3:0] st_of(input int d);
      case (d)
         0: return {pv2, er2, vo2, hb2};
         1: return {pv3, er3, vo3, hb3};
         default: return {pv4, er4, vo4, hb4};
      endcase
   endfunction

   function automatic longint pdata_of(input int d);
      case (d)
         0: return longint'(po2);
         1: return longint'(po3);
         default: return longint'(po4);
      endcase
   endfunction

   // Pixel j of the current line: byte k goes to byte lane (BPP-1-k) when
   // MSB-first, lane k otherwise; lanes start at zero for each pixel.
   function automatic longint exp_pix(input int bpp, input int j);
      longint v;
      int     idx, pos;
      bit     m;
      v = 0;
      for (int k = 0; k < bpp; k++) begin
         idx = j * bpp + k;
`ifdef CMOS_PACK_BYTE_SWAP_EN
         m = cur_msb[idx];
`else
         m = 1'b1;
`endif
         pos = m ? (bpp - 1 - k) : k;
         v = (v & ~(longint'(64'hff) << (8 * pos))) | (longint'(cur_bytes[idx]) << (8 * pos));
      end
      return v;
   endfunction

   task automatic clear_mon;
      mq2.delete(); mq3.delete(); mq4.delete();
      for (int d = 0; d < 3; d++) begin ec[d] = 0; fc[d] = -1; end
   endtask

   // Called at a negedge; drives cur_bytes as one line, then de_i low for
   // gap cycles. Returns at a negedge.
   task automatic run_line(input int gap, input bit vs_end);
      clear_mon();
      vs_i = 1'b0;
      start_cyc = cyc;
      for (int i = 0; i < cur_bytes.size(); i++) begin
         if (i > 0) @(negedge pclk);
         de_i = 1'b1;
         pdata_i = cur_bytes[i];
         msb_first = cur_msb[i];
      end
      @(negedge pclk);
      de_i = 1'b0;
      pdata_i = 8'($urandom);
      vs_i = vs_end;
      if (vs_end) begin
         #1;
         n_tests++;
         if (vo2 !== 1'b0) begin
            n_fail++;
            $display("FAIL vs_o_early: got %0b expected 0", vo2);
         end
      end
      repeat (gap) @(negedge pclk);
   endtask

   task automatic check_line(input bit vs);
      int len;
      len = cur_bytes.size();
      for (int d = 0; d < 3; d++) begin
         int bpp, cmax, npix, got_n, epc, eerr;
         bpp   = d + 2;
         cmax  = (d == 2) ? 7 : 4095;
         npix  = len / bpp;
         got_n = mon_size(d);
         n_tests++;
         if (got_n !== npix) begin
            n_fail++;
            $display("FAIL npix bpp%0d: got %0d expected %0d", bpp, got_n, npix);
         end
         for (int j = 0; j < npix && j < got_n; j++) begin
            n_tests++;
            if (mon_val(d, j) !== exp_pix(bpp, j)) begin
               n_fail++;
               $display("FAIL pixel bpp%0d #%0d: got %0h expected %0h",
                        bpp, j, mon_val(d, j), exp_pix(bpp, j));
            end
         end
         if (npix > 0 && got_n > 0) begin
            n_tests++;
            if (fc[d] - start_cyc !== bpp) begin
               n_fail++;
               $display("FAIL latency bpp%0d: got %0d expected %0d", bpp, fc[d] - start_cyc, bpp);
            end
         end
         eerr = ((len % bpp) != 0) ? 1 : 0;
         n_tests++;
         if (ec[d] !== eerr) begin
            n_fail++;
            $display("FAIL err_partial bpp%0d: got %0d pulses expected %0d", bpp, ec[d], eerr);
         end
         epc = vs ? 0 : ((npix > cmax) ? cmax : npix);
         n_tests++;
         if (pix_of(d) !== epc) begin
            n_fail++;
            $display("FAIL pix_cnt bpp%0d: got %0d expected %0d", bpp, pix_of(d), epc);
         end
         if (vs) line_exp[d] = 0;
         else if (npix > 0 && line_exp[d] < cmax) line_exp[d]++;
         n_tests++;
         if (line_of(d) !== line_exp[d]) begin
            n_fail++;
            $display("FAIL line_cnt bpp%0d: got %0d expected %0d", bpp, line_of(d), line_exp[d]);
         end
      end
      n_tests++;
      if (st_of(0)[1:0] !== {vs, 1'b1}) begin
         n_fail++;
         $display("FAIL vs_o/hblank: got %b expected %b", st_of(0)[1:0], {vs, 1'b1});
      end
   endtask

   task automatic check_reset_vals(input string tag);
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if (st_of(d) !== 4'b0001) begin
            n_fail++;
            $display("FAIL %s flags bpp%0d: got %b expected 0001", tag, d + 2, st_of(d));
         end
         n_tests++;
         if (pdata_of(d) !== 0) begin
            n_fail++;
            $display("FAIL %s pdata bpp%0d: got %0h expected 0", tag, d + 2, pdata_of(d));
         end
         n_tests++;
         if (pix_of(d) !== 0 || line_of(d) !== 0) begin
            n_fail++;
            $display("FAIL %s counters bpp%0d: got pix %0d line %0d expected 0 0",
                     tag, d + 2, pix_of(d), line_of(d));
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; de_i = 1'b0; vs_i = 1'b0; msb_first = 1'b1; pdata_i = 8'h00;
      #2;
      check_reset_vals("reset_async");
      repeat (2) @(negedge pclk);
      check_reset_vals("reset_held");
      rst = 1'b0;
      @(negedge pclk);
      for (int d = 0; d < 3; d++) line_exp[d] = 0;
   endtask

   task automatic test_basic;
      cur_bytes.delete(); cur_msb.delete();
      for (int i = 0; i < 800; i++) begin
         cur_bytes.push_back(8'(i));
         cur_msb.push_back(1'b1);
      end
      run_line(2, 1'b0);
      n_tests++;
      if (mq2.size() !== 400 || (mq2.size() > 0 && mq2[0] !== 64'h0001)) begin
         n_fail++;
         $display("FAIL basic_first: got count %0d expected 400 first 0001", mq2.size());
      end
      n_tests++;
      if (pc2 !== 12'd400 || lc2 !== 12'd1) begin
         n_fail++;
         $display("FAIL basic_counts: got pix %0d line %0d expected 400 1", pc2, lc2);
      end
      check_line(1'b0);
   endtask

   task automatic test_partial;
      cur_bytes.delete(); cur_msb.delete();
      for (int i = 0; i < 7; i++) begin
         cur_bytes.push_back(8'($urandom));
         cur_msb.push_back(1'b1);
      end
      run_line(1, 1'b0);
      n_tests++;
      if (mq3.size() !== 2 || ec[1] !== 1 || pc3 !== 12'd2) begin
         n_fail++;
         $display("FAIL partial_bpp3: got pix %0d err %0d cnt %0d expected 2 1 2",
                  mq3.size(), ec[1], pc3);
      end
      check_line(1'b0);
   endtask

   task automatic test_order;
      longint exp4;
`ifdef CMOS_PACK_BYTE_SWAP_EN
      exp4 = 64'h44332211;
`else
      exp4 = 64'h11223344;
`endif
      cur_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      cur_msb   = '{1'b0, 1'b0, 1'b0, 1'b0};
      run_line(1, 1'b0);
      n_tests++;
      if (mq4.size() < 1 || mq4[0] !== exp4) begin
         n_fail++;
         $display("FAIL order_bpp4: got %0h expected %0h",
                  (mq4.size() > 0) ? mq4[0] : 64'hdead, exp4);
      end
      check_line(1'b0);
   endtask

   task automatic test_random;
      for (int r = 0; r < 14; r++) begin
         int len, gap;
         len = $urandom_range(1, 40);
         gap = $urandom_range(1, 3);
         cur_bytes.delete(); cur_msb.delete();
         for (int i = 0; i < len; i++) begin
            cur_bytes.push_back(8'($urandom));
            cur_msb.push_back(1'($urandom_range(0, 1)));
         end
         run_line(gap, 1'b0);
         check_line(1'b0);
      end
   endtask

   task automatic test_vsync;
      for (int l = 0; l < 5; l++) begin
         bit vs;
         vs = (l == 0 || l == 4);
         cur_bytes.delete(); cur_msb.delete();
         for (int i = 0; i < 8; i++) begin
            cur_bytes.push_back(8'($urandom));
            cur_msb.push_back(1'b1);
         end
         if (l == 4) begin
            n_tests++;
            if (lc2 !== 12'd3) begin
               n_fail++;
               $display("FAIL vsync_before: got %0d expected 3", lc2);
            end
         end
         run_line(2, vs);
         check_line(vs);
      end
   endtask

   task automatic test_reset_midline;
      for (int i = 0; i < 5; i++) begin
         de_i = 1'b1; msb_first = 1'b1; pdata_i = 8'($urandom);
         @(negedge pclk);
      end
      rst = 1'b1;
      pdata_i = 8'($urandom);
      #1;
      check_reset_vals("reset_midline");
      #1;
      rst = 1'b0;
      clear_mon();
      for (int d = 0; d < 3; d++) line_exp[d] = 0;
      repeat (6) begin
         @(negedge pclk);
         pdata_i = 8'($urandom);
      end
      @(negedge pclk);
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if (mon_size(d) !== 0 || ec[d] !== 0) begin
            n_fail++;
            $display("FAIL after_reset bpp%0d: got %0d pixels %0d errs expected 0 0",
                     d + 2, mon_size(d), ec[d]);
         end
      end
      de_i = 1'b0;
      @(negedge pclk);
      cur_bytes.delete(); cur_msb.delete();
      for (int i = 0; i < 12; i++) begin
         cur_bytes.push_back(8'($urandom));
         cur_msb.push_back(1'($urandom_range(0, 1)));
      end
      run_line(1, 1'b0);
      check_line(1'b0);
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_basic();
      test_partial();
      test_order();
      test_random();
      test_vsync();
      test_reset_midline();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
